regfile_wr_arbiter: RTL and testbench

//  Shares the single write port of the 32x64 register file between two writeback requesters:
//  A = ALU writeback, B = memory-load writeback. Each requester uses a valid/ready handshake.

---
 rtl/regfile_wr_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin share of the register-file write port between ALU (A) and load (B)
// writeback, plus a one-register-per-cycle clear sweep. Optional macro REGFILE_XZR_PROTECT_EN makes
// the top register (XZR) read-only to the requesters.
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data
);
    typedef enum logic {S_ARB, S_CLEAR} state_t;

    state_t                r_state, w_next;
    logic                  r_rr_last;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_rf_write;
    logic [ADDR_WIDTH-1:0] r_rf_wr_addr;
    logic [DATA_WIDTH-1:0] r_rf_wr_data;
    logic                  w_arb, w_a_grant, w_b_grant, w_a_xzr, w_b_xzr, w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

`ifdef REGFILE_XZR_PROTECT_EN
    assign w_a_xzr = (a_addr == {ADDR_WIDTH{1'b1}});
    assign w_b_xzr = (b_addr == {ADDR_WIDTH{1'b1}});
`else
    assign w_a_xzr = 1'b0;
    assign w_b_xzr = 1'b0;
`endif

    // Grant selection, next state and the value to register toward the file; r_rr_last=1 means B won last
    always_comb begin
        w_arb     = (r_state == S_ARB) && !clear_req && !reset;
        w_a_grant = w_arb && a_valid && (!b_valid || r_rr_last);
        w_b_grant = w_arb && b_valid && (!a_valid || !r_rr_last);
        w_wr_en   = (r_state == S_CLEAR) || (w_a_grant && !w_a_xzr) || (w_b_grant && !w_b_xzr);
        w_wr_addr = (r_state == S_CLEAR) ? r_clr_cnt : (w_a_grant ? a_addr : b_addr);
        w_wr_data = (r_state == S_CLEAR) ? '0 : (w_a_grant ? a_data : b_data);
        w_next    = r_state;
        if (r_state == S_ARB && clear_req)
            w_next = S_CLEAR;
        else if (r_state == S_CLEAR && r_clr_cnt == {ADDR_WIDTH{1'b1}})
            w_next = S_ARB;
    end

    // State, round-robin pointer, clear counter and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_ARB;
            r_rr_last    <= 1'b1;
            r_clr_cnt    <= '0;
            r_rf_write   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wr_data <= '0;
        end else begin
            r_state    <= w_next;
            r_rf_write <= w_wr_en;
            if (w_a_grant)
                r_rr_last <= 1'b0;
            else if (w_b_grant)
                r_rr_last <= 1'b1;
            if (r_state == S_CLEAR)
                r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_wr_en) begin
                r_rf_wr_addr <= w_wr_addr;
                r_rf_wr_data <= w_wr_data;
            end
        end
    end

    assign a_ready    = w_a_grant;
    assign b_ready    = w_b_grant;
    assign clear_busy = (r_state == S_CLEAR);
    assign rf_write   = r_rf_write;
    assign rf_wr_addr = r_rf_wr_addr;
    assign rf_wr_data = r_rf_wr_data;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, clear_req;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        a_ready, b_ready, clear_busy, rf_write;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    int          checks = 0;
    int          errors = 0;

    regfile_wr_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .rf_write(rf_write), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; clear_req = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        a_valid = 1;
        b_valid = 1;
        #1;
        checks++;
        if ({rf_write, rf_wr_addr, rf_wr_data, a_ready, b_ready, clear_busy} !== 72'd0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%0b addr=%0d data=%h ar=%0b br=%0b busy=%0b, want all 0",
                     rf_write, rf_wr_addr, rf_wr_data, a_ready, b_ready, clear_busy);
        end
        idle_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        a_valid = 1; a_addr = 3; a_data = 64'hDEAD_BEEF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got a=%0b b=%0b, want a=1 b=0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 0;
        checks++;
        if (rf_write !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: got wr=%0b addr=%0d data=%h, want 1 3 deadbeef",
                     rf_write, rf_wr_addr, rf_wr_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_write !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got wr=%0b, want 0", rf_write);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        a_valid = 1; a_addr = 1; a_data = 64'h11;
        b_valid = 1; b_addr = 2; b_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got a=%0b b=%0b, want a=%0b b=%0b",
                         i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
            end
            @(posedge clk); #1;
            checks++;
            if (rf_write !== 1'b1 || rf_wr_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
                errors++;
                $display("FAIL alt_write[%0d]: got wr=%0b addr=%0d, want 1 %0d",
                         i, rf_write, rf_wr_addr, (i % 2 == 0) ? 1 : 2);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear_req = 1;
        a_valid = 1; a_addr = 7; a_data = 64'h77;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_nogrant: got a=%0b b=%0b, want 0 0", a_ready, b_ready);
        end
        @(negedge clk);
        clear_req = 0;
        checks++;
        if (clear_busy !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: got busy=%0b a=%0b, want 1 0", clear_busy, a_ready);
        end
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rf_write !== 1'b1 || rf_wr_addr !== 5'(k) || rf_wr_data !== 64'd0 ||
                clear_busy !== (k < 31) || a_ready !== (k == 31)) begin
                errors++;
                $display("FAIL clear_sweep[%0d]: got wr=%0b addr=%0d data=%h busy=%0b a=%0b, want 1 %0d 0 %0b %0b",
                         k, rf_write, rf_wr_addr, rf_wr_data, clear_busy, a_ready, k, k < 31, k == 31);
            end
            if (k == 5) clear_req = 1;
            if (k == 6) clear_req = 0;
        end
        @(posedge clk); #1;
        a_valid = 0;
        checks++;
        if (rf_write !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 64'h77 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got wr=%0b addr=%0d data=%h busy=%0b, want 1 7 77 0",
                     rf_write, rf_wr_addr, rf_wr_data, clear_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (rf_wr_addr !== 5'd9 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_pos: got addr=%0d busy=%0b, want 9 1", rf_wr_addr, clear_busy);
        end
        reset = 1;
        #1;
        checks++;
        if ({rf_write, rf_wr_addr, rf_wr_data, a_ready, b_ready, clear_busy} !== 72'd0) begin
            errors++;
            $display("FAIL midclear_reset: got wr=%0b addr=%0d data=%h busy=%0b, want all 0",
                     rf_write, rf_wr_addr, rf_wr_data, clear_busy);
        end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rf_write !== 1'b1 || rf_wr_addr !== 5'(k)) begin
                errors++;
                $display("FAIL restart_sweep[%0d]: got wr=%0b addr=%0d, want 1 %0d", k, rf_write, rf_wr_addr, k);
            end
        end
        repeat (31) @(posedge clk);
        #1;
        checks++;
        if (clear_busy !== 1'b0 || rf_wr_addr !== 5'd31) begin
            errors++;
            $display("FAIL restart_done: got busy=%0b addr=%0d, want 0 31", clear_busy, rf_wr_addr);
        end
    endtask

    task automatic test_xzr();
        @(negedge clk);
        b_valid = 1; b_addr = 31; b_data = 64'd5;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL xzr_ready: got a=%0b b=%0b, want 0 1", a_ready, b_ready);
        end
        @(posedge clk); #1;
        b_valid = 0;
        checks++;
`ifdef REGFILE_XZR_PROTECT_EN
        if (rf_write !== 1'b0 || rf_wr_addr !== 5'd31 || rf_wr_data !== 64'd0) begin
            errors++;
            $display("FAIL xzr_write: got wr=%0b addr=%0d data=%h, want 0 31 0", rf_write, rf_wr_addr, rf_wr_data);
        end
`else
        if (rf_write !== 1'b1 || rf_wr_addr !== 5'd31 || rf_wr_data !== 64'd5) begin
            errors++;
            $display("FAIL xzr_write: got wr=%0b addr=%0d data=%h, want 1 31 5", rf_write, rf_wr_addr, rf_wr_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_clear();
        test_reset_mid_clear();
        test_xzr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
